// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage of a 5-stage RISC-V pipeline. Performs
//               single-cycle ALU operations and a multi-cycle shift-add
//               multiply. The result is held in an EX/MEM output register.
//               A stall is raised toward the hazard logic while a multiply
//               is in flight.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               valid_in, flush_in  - live instruction / kill in-flight op
//               data_1_in/data_2_in - rs1 / rs2 values
//               imm_in, ALU_src_in  - immediate and operand-B select
//               ALU_ctrl_in, Rd_in  - operation select, destination reg
//               result_out, data_2_out, Rd_out, valid_out, reg_write_out
//                                   - registered EX/MEM outputs
//               stall_out           - combinational hold request upstream
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            flush_in,
    input  logic [XLEN-1:0] data_1_in,
    input  logic [XLEN-1:0] data_2_in,
    input  logic [4:0]      Rd_in,
    input  logic [3:0]      ALU_ctrl_in,
    input  logic            ALU_src_in,
    input  logic [XLEN-1:0] imm_in,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] data_2_out,
    output logic [4:0]      Rd_out,
    output logic            valid_out,
    output logic            reg_write_out,
    output logic            stall_out
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SLL  = 4'b0101;
    localparam logic [3:0] c_OP_SRL  = 4'b0110;
    localparam logic [3:0] c_OP_SRA  = 4'b0111;
    localparam logic [3:0] c_OP_SLT  = 4'b1000;
    localparam logic [3:0] c_OP_SLTU = 4'b1001;
    localparam logic [3:0] c_OP_MUL  = 4'b1010;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_d2_lat;
    logic [4:0]       r_rd_lat;
    logic [XLEN-1:0]  r_result;
    logic [XLEN-1:0]  r_data_2;
    logic [4:0]       r_rd;
    logic             r_valid;

    logic [XLEN-1:0]  w_b;
    logic [4:0]       w_shamt;
    logic [XLEN-1:0]  w_alu;
    logic [XLEN-1:0]  w_acc_next;
    logic             w_is_mul;
    logic             w_cnt_last;

    assign w_b        = ALU_src_in ? imm_in : data_2_in;
    assign w_shamt    = w_b[4:0];
    assign w_is_mul   = (ALU_ctrl_in == c_OP_MUL);
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // One shift-add iteration: add the multiplicand when the current
    // multiplier LSB is set. The last iteration's sum is the final product.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_alu = '0;
        case (ALU_ctrl_in)
            c_OP_ADD:  w_alu = data_1_in + w_b;
            c_OP_SUB:  w_alu = data_1_in - w_b;
            c_OP_AND:  w_alu = data_1_in & w_b;
            c_OP_OR:   w_alu = data_1_in | w_b;
            c_OP_XOR:  w_alu = data_1_in ^ w_b;
            c_OP_SLL:  w_alu = data_1_in << w_shamt;
            c_OP_SRL:  w_alu = data_1_in >> w_shamt;
            c_OP_SRA:  w_alu = $unsigned($signed(data_1_in) >>> w_shamt);
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(data_1_in) < $signed(w_b))};
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (data_1_in < w_b)};
            default:   w_alu = '0;  // MUL handled by the iterative path; reserved codes give 0
        endcase
    end

    // Flush overrides everything so the hazard unit never waits on a killed
    // multiply. In BUSY the stall releases during the final iteration so that
    // ID/EX advances on the same edge the product is written.
    always_comb begin
        stall_out = 1'b0;
        if (!flush_in) begin
            if (r_state == c_IDLE) begin
                stall_out = valid_in && w_is_mul;
            end else begin
                stall_out = !w_cnt_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_d2_lat <= '0;
            r_rd_lat <= '0;
            r_result <= '0;
            r_data_2 <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
        end else if (flush_in) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (valid_in) begin
                if (w_is_mul) begin
                    r_mcand  <= data_1_in;
                    r_mplier <= w_b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_d2_lat <= data_2_in;
                    r_rd_lat <= Rd_in;
                    r_valid  <= 1'b0;
                    r_state  <= c_BUSY;
                end else begin
                    r_result <= w_alu;
                    r_data_2 <= data_2_in;
                    r_rd     <= Rd_in;
                    r_valid  <= 1'b1;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_cnt_last) begin
                // Return to IDLE without looking at the inputs: the MUL still
                // shown upstream this cycle is the one just completed.
                r_result <= w_acc_next;
                r_data_2 <= r_d2_lat;
                r_rd     <= r_rd_lat;
                r_valid  <= 1'b1;
                r_cnt    <= '0;
                r_state  <= c_IDLE;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_valid <= 1'b0;
            end
        end
    end

    assign result_out    = r_result;
    assign data_2_out    = r_data_2;
    assign Rd_out        = r_rd;
    assign valid_out     = r_valid;
    assign reg_write_out = r_valid && (r_rd != 5'd0);

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline, directly downstream of the ID/EX register. It consumes the operands, destination register, ALU control, ALU_src select and immediate that ID/EX produces.
- Computes single-cycle ALU results and a multi-cycle 32-bit shift-add multiply (MUL).
- Holds its result in an internal EX/MEM output register.
- Asserts a stall back to the hazard logic while a multiply is in progress.

Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, multiply iterations (one bit of operand B per iteration; must equal XLEN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  ID/EX holds a live instruction
- flush_in  input  1  kill the in-flight instruction (branch mispredict)
- data_1_in  input  XLEN  rs1 value
- data_2_in  input  XLEN  rs2 value
- Rd_in  input  5  destination register
- ALU_ctrl_in  input  4  operation select
- ALU_src_in  input  1  1 = operand B is imm_in, 0 = operand B is data_2_in
- imm_in  input  XLEN  sign-extended immediate
- result_out  output  XLEN  registered ALU/MUL result
- data_2_out  output  XLEN  registered rs2 value (store data)
- Rd_out  output  5  registered destination
- valid_out  output  1  result_out is live
- reg_write_out  output  1  valid_out && Rd_out != 0
- stall_out  output  1  combinational; upstream must hold ID/EX while high

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all registered outputs 0; FSM goes to IDLE; iteration counter 0.
- Reset mid-multiply: the multiply is aborted; no result is emitted.
- Operands: A = data_1_in. B = ALU_src_in ? imm_in : data_2_in.
- ALU_ctrl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA (shift amount = B[4:0])
  - 1000 SLT (signed), 1001 SLTU (unsigned); result is 0 or 1
  - 1010 MUL (low 32 bits of the product)
  - 1011-1111 reserved: result 0, still valid
- Arithmetic wraps modulo 2^32; no overflow flag.
- Single-cycle ops, in IDLE with valid_in=1:
  - At the next edge: result_out, data_2_out, Rd_out register; valid_out=1.
  - Latency is 1 edge.
- valid_in=0 in IDLE: valid_out=0 at the next edge (bubble). The other outputs may hold any value.
- FSM states: IDLE, BUSY.
- IDLE with valid_in=1 and ALU_ctrl=MUL:
  - stall_out=1 immediately.
  - At the edge: latch A into the multiplicand, B into the multiplier, latch Rd_in and data_2_in; clear the accumulator; cnt=0; go to BUSY; valid_out=0.
- BUSY, each cycle:
  - If multiplier[0] is 1, the accumulator adds the multiplicand.
  - Then the multiplicand shifts left 1, the multiplier shifts right 1, and cnt increments.
  - stall_out = (cnt != MUL_CYCLES-1).
  - valid_out stays 0.
- BUSY with cnt == MUL_CYCLES-1:
  - At the edge: result_out = final accumulator; Rd_out and data_2_out take the latched values; valid_out=1; go to IDLE.
  - stall_out is already 0 during this cycle, so ID/EX advances at the same edge.
  - The stale MUL still visible on the inputs that cycle is not restarted.
- MUL timing summary:
  - stall_out is high for exactly 32 consecutive cycles.
  - The result is valid after the 33rd edge, counted from the first cycle the MUL is presented.
  - Back-to-back MULs: the second MUL enters from IDLE on the following cycle.
- flush_in=1, highest priority after reset:
  - At the next edge: valid_out=0, FSM to IDLE, cnt=0.
  - stall_out=0 while flush_in=1.
  - The instruction on the inputs that cycle is discarded.
- valid_in and flush_in together: flush wins.
- BUSY ignores valid_in and all data inputs; upstream holds them.
- Rd_in=0: the result is computed and valid_out=1, but reg_write_out=0.

Test Plan:
- Reset: assert reset for 2 cycles mid-stream → all outputs 0, stall_out=0. Then ADD 5+7, Rd=3 → one edge later result_out=12, valid_out=1, reg_write_out=1.
- ALU sweep: A=0xFFFFFFF0, B=imm=4 (ALU_src=1).
  - ADD → 0xFFFFFFF4; SUB → 0xFFFFFFEC.
  - SRA → 0xFFFFFFFF; SRL → 0x0FFFFFFF.
  - SLT → 1; SLTU → 0.
  - With ALU_src=0 and data_2=8: ADD → 0xFFFFFFF8.
- MUL 0x12345678 * 3, Rd=5 → stall_out high 32 cycles; valid_out=0 throughout; result_out=0x369D0368 with Rd_out=5, valid_out=1 after edge 33. MUL 0xFFFFFFFF * 0xFFFFFFFF → 0x00000001.
- Back-to-back: MUL 6*7 then ADD 1+1 held behind the stall → 42 emitted, then 2 on the very next edge, no duplicate MUL.
- Flush at BUSY cnt=10 → valid_out=0, stall_out drops in the same cycle, FSM to IDLE; the next ADD completes in 1 edge. Reset at cnt=20 → same abort, all outputs 0.
- Rd=0 with ADD 9+9 → result_out=18, valid_out=1, reg_write_out=0. Reserved ctrl 1111 → result_out=0, valid_out=1.
